// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one slave bus between fetch (I) and mem-stage (D) masters with timeout watchdog
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic [DATA_W-1:0]   i_data_o,
    output logic                i_ack_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_sel_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_ack_o,
    output logic                err_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i,
    output logic                stallreq_if_o,
    output logic                stallreq_mem_o
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
    state_t              state_q;
    logic [7:0]          cnt_q;
    logic                bus_req_q;
    logic                bus_we_q;
    logic [DATA_W/8-1:0] bus_sel_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic                busy;
    logic                tmo;
    logic                fin;
    assign busy = state_q != IDLE;
    // a real ack in the last watchdog cycle wins over the timeout
    assign tmo = busy & ~bus_ack_i & (cnt_q == 8'(TIMEOUT - 1));
    assign fin = (busy & bus_ack_i) | tmo;
    assign i_ack_o = (state_q == GNT_I) & fin;
    assign d_ack_o = (state_q == GNT_D) & fin;
    assign err_o = tmo;
    assign i_data_o = (i_ack_o & bus_ack_i) ? bus_rdata_i : '0;
    assign d_rdata_o = (d_ack_o & bus_ack_i) ? bus_rdata_i : '0;
    assign stallreq_if_o = i_req_i & ~i_ack_o;
    assign stallreq_mem_o = d_req_i & ~d_ack_o;
    assign bus_req_o = bus_req_q;
    assign bus_we_o = bus_we_q;
    assign bus_sel_o = bus_sel_q;
    assign bus_addr_o = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    // grant FSM: D has fixed priority, bus registers latched at grant and held until completion
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
            if (d_req_i) begin
                state_q     <= GNT_D;
                bus_req_q   <= 1'b1;
                bus_we_q    <= d_we_i;
                bus_sel_q   <= d_sel_i;
                bus_addr_q  <= d_addr_i;
                bus_wdata_q <= d_wdata_i;
            end else if (i_req_i) begin
                state_q     <= GNT_I;
                bus_req_q   <= 1'b1;
                bus_we_q    <= 1'b0;
                bus_sel_q   <= '1;
                bus_addr_q  <= i_addr_i;
                bus_wdata_q <= '0;
            end
        end else if (fin) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
endmodule
